// File: rtl/memory_responder_if.sv
// memory_responder_if: CPU-side bus between the core and memory_responder.
// Latency: none, wires only.
// Backpressure: ready is the responder's completion pulse; the core holds cpu_req until it sees it.
interface memory_responder_if;
   logic        cpu_req;    // bus cycle pending, held until ready
   logic [15:0] cpu_addr;   // request address
   logic        cpu_rw;     // 1 = read, 0 = write
   logic [7:0]  cpu_wdata;  // write data
   logic        ready;      // one-cycle completion pulse, feeds the core's enableFFs
   logic [7:0]  cpu_rdata;  // registered read data

   modport master (
      output cpu_req, cpu_addr, cpu_rw, cpu_wdata,
      input  ready, cpu_rdata
   );

   modport slave (
      input  cpu_req, cpu_addr, cpu_rw, cpu_wdata,
      output ready, cpu_rdata
   );
endinterface

// File: rtl/memory_responder.sv
// memory_responder: latches CPU requests, inserts address-based wait states, returns registered read data; MEM_RESP_WRITE_PROTECT_EN blocks writes at/above ROM_BASE.
// Latency: ready 2 cycles after the request is sampled below FAST_LIMIT, 2+SLOW_WAIT cycles at or above it.
// Backpressure: ready low stalls the core; cpu_* sampled only in IDLE, so at most one request per 3+W cycles.
module memory_responder #(
   parameter logic [15:0] FAST_LIMIT = 16'h8000,
   parameter int unsigned SLOW_WAIT  = 2,
   parameter logic [15:0] ROM_BASE   = 16'hE000
) (
   input  logic               clk,
   input  logic               rst,
   memory_responder_if.slave  cpu,
   output logic [15:0]        mem_addr,
   output logic [7:0]         mem_wdata,
   output logic               mem_we,
   input  logic [7:0]         mem_rdata,
   output logic               wr_fault
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] ACK    = 2'd2;

   // The wait counter is 4 bits wide, so SLOW_WAIT is meaningful in 0..15.
   localparam logic [3:0] SLOW_LOAD = 4'(SLOW_WAIT);

   logic [1:0] state;
   logic [3:0] wait_cnt;
   logic       rw_q;         // latched direction of the request in flight
   logic       last_access;  // final ACCESS cycle: data capture / write strobe happen here
   logic       write_hit;    // a write would strobe memory in this cycle
   logic       blocked;      // the write in flight targets protected space

   assign last_access = (state == ACCESS) && (wait_cnt == 4'd0);

   // Gating with rst keeps an abandoned access from strobing memory in the reset cycle.
   assign write_hit = last_access && !rw_q && !rst;

`ifdef MEM_RESP_WRITE_PROTECT_EN
   assign blocked = (mem_addr >= ROM_BASE);
`else
   logic unused_rom_base;
   assign blocked         = 1'b0;
   assign unused_rom_base = ^ROM_BASE;
`endif

   // A blocked write keeps its slot in time: the fault pulse replaces the strobe and ACK follows as usual.
   assign mem_we   = write_hit && !blocked;
   assign wr_fault = write_hit && blocked;

   // ready is a pure state decode, so there is no combinational path from cpu_* to it.
   assign cpu.ready = (state == ACK);

   // Sequencer: sample in IDLE, count down wait states in ACCESS, one ACK cycle, then back to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu.cpu_req) begin
                  wait_cnt <= (cpu.cpu_addr < FAST_LIMIT) ? 4'd0 : SLOW_LOAD;
                  state    <= ACCESS;
               end
            end
            ACCESS: begin
               if (wait_cnt != 4'd0) begin
                  wait_cnt <= wait_cnt - 4'd1;
               end else begin
                  state <= ACK;
               end
            end
            ACK: begin
               state <= IDLE;
            end
            default: begin
               state    <= IDLE;
               wait_cnt <= 4'd0;
            end
         endcase
      end
   end

   // Request latches and read-data capture; the latches stay put until the next IDLE sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr      <= 16'h0000;
         mem_wdata     <= 8'h00;
         rw_q          <= 1'b1;
         cpu.cpu_rdata <= 8'h00;
      end else begin
         if ((state == IDLE) && cpu.cpu_req) begin
            mem_addr  <= cpu.cpu_addr;
            mem_wdata <= cpu.cpu_wdata;
            rw_q      <= cpu.cpu_rw;
         end
         if (last_access && rw_q) begin
            cpu.cpu_rdata <= mem_rdata;
         end
      end
   end

   // ready must never be high two cycles running.
   a_ready_pulse: assert property (@(posedge clk) disable iff (rst) cpu.ready |=> !cpu.ready);

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: table vectors, hand sequences and random requests against a spec-level model.
// Latency: checks ready/mem_we/wr_fault cycle positions per transaction.
// Backpressure: holds cpu_req until ready, scrambling cpu_* meanwhile.
module tb_memory_responder;

   localparam int SLOW_W = 2;
`ifdef MEM_RESP_WRITE_PROTECT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_we;
   logic        wr_fault;

   logic [7:0]  mem       [0:65535];
   logic [7:0]  model_mem [0:65535];
   logic [7:0]  last_rdata;
   logic [15:0] edge_addrs [6] = '{16'h0000, 16'h7FFF, 16'h8000, 16'hDFFF, 16'hE000, 16'hFFFF};

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        rd;
      logic [15:0] addr;
      logic [7:0]  wd;
      logic        pre_en;
      logic [7:0]  pre_val;
      int          rdy;
      int          we;
      int          flt;
      logic [7:0]  rdata;
      logic [7:0]  mem_after;
   } vec_t;

   vec_t vecs [9];

   memory_responder_if bus ();

   memory_responder dut (
      .clk       (clk),
      .rst       (rst),
      .cpu       (bus),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .wr_fault  (wr_fault)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Runs one request starting at posedge+1 of cycle 0; memory writes are applied when mem_we is seen.
   task automatic do_txn(input string tag, input logic rd, input logic [15:0] a, input logic [7:0] wd,
                         input int e_rdy, input int e_we, input int e_flt,
                         input logic [7:0] e_rdata, input logic [7:0] e_mem);
      int          rdy_at = -1;
      int          we_at  = -1;
      int          flt_at = -1;
      int          n_rdy  = 0;
      int          n_we   = 0;
      int          n_flt  = 0;
      logic [15:0] we_addr = '0;
      logic [15:0] addr_at_rdy = '0;
      logic [7:0]  we_data = '0;
      logic [7:0]  rdata_at_rdy = '0;
      logic [7:0]  rdata_after = '0;
      bus.cpu_req   = 1'b1;
      bus.cpu_addr  = a;
      bus.cpu_rw    = rd;
      bus.cpu_wdata = wd;
      for (int c = 0; c < 10; c++) begin
         if (c > 0 && rdy_at < 0) begin
            bus.cpu_addr  = 16'($urandom);
            bus.cpu_wdata = 8'($urandom);
            bus.cpu_rw    = 1'($urandom);
         end
         if (rdy_at >= 0) bus.cpu_req = 1'b0;
         @(negedge clk);
         if (bus.ready) begin
            n_rdy++;
            if (rdy_at < 0) begin
               rdy_at       = c;
               addr_at_rdy  = mem_addr;
               rdata_at_rdy = bus.cpu_rdata;
            end
         end
         if (rdy_at >= 0 && c == rdy_at + 1) rdata_after = bus.cpu_rdata;
         if (mem_we) begin
            n_we++;
            we_at   = c;
            we_addr = mem_addr;
            we_data = mem_wdata;
            mem[mem_addr] = mem_wdata;
         end
         if (wr_fault) begin
            n_flt++;
            flt_at = c;
         end
         @(posedge clk);
         #1;
      end
      bus.cpu_req = 1'b0;
      chk({tag, " ready cycle"}, rdy_at, e_rdy);
      chk({tag, " ready pulses"}, n_rdy, 1);
      chk({tag, " we cycle"}, we_at, e_we);
      chk({tag, " we count"}, n_we, (e_we >= 0) ? 1 : 0);
      chk({tag, " fault cycle"}, flt_at, e_flt);
      chk({tag, " fault count"}, n_flt, (e_flt >= 0) ? 1 : 0);
      chk({tag, " mem_addr held"}, int'(addr_at_rdy), int'(a));
      chk({tag, " rdata"}, int'(rdata_at_rdy), int'(e_rdata));
      chk({tag, " rdata held"}, int'(rdata_after), int'(e_rdata));
      if (e_we >= 0) begin
         chk({tag, " we addr"}, int'(we_addr), int'(a));
         chk({tag, " we data"}, int'(we_data), int'(wd));
      end
      if (!rd) chk({tag, " mem content"}, int'(mem[a]), int'(e_mem));
      last_rdata = e_rdata;
      if (!rd) model_mem[a] = e_mem;
   endtask

   initial begin
      int          sq_we;
      int          sq_rdy;
      logic [9:0]  rdy_mask;
      logic        rd;
      logic [15:0] a;
      logic [7:0]  wd;
      int          w;
      bit          blk;

      for (int i = 0; i < 65536; i++) begin
         mem[i]       = 8'($urandom);
         model_mem[i] = mem[i];
      end
      last_rdata = 8'h00;

      rst           = 1'b1;
      bus.cpu_req   = 1'b0;
      bus.cpu_addr  = 16'h0000;
      bus.cpu_rw    = 1'b1;
      bus.cpu_wdata = 8'h00;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset ready", int'(bus.ready), 0);
      chk("reset mem_we", int'(mem_we), 0);
      chk("reset wr_fault", int'(wr_fault), 0);
      chk("reset cpu_rdata", int'(bus.cpu_rdata), 0);
      chk("reset mem_addr", int'(mem_addr), 0);
      chk("reset mem_wdata", int'(mem_wdata), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("idle ready", int'(bus.ready), 0);
      @(posedge clk);
      #1;

      // Directed table: {rd, addr, wdata, preload?, preload value, ready cyc, we cyc, fault cyc, rdata, mem after}
      vecs[0] = '{1'b1, 16'h0010, 8'h00, 1'b1, 8'hA5, 2, -1, -1, 8'hA5, 8'h00};
      vecs[1] = '{1'b1, 16'h9000, 8'h00, 1'b1, 8'h3C, 4, -1, -1, 8'h3C, 8'h00};
      vecs[2] = '{1'b0, 16'h0200, 8'h77, 1'b0, 8'h00, 2,  1, -1, 8'h3C, 8'h77};
      vecs[3] = '{1'b1, 16'h7FFF, 8'h00, 1'b1, 8'h01, 2, -1, -1, 8'h01, 8'h00};
      vecs[4] = '{1'b1, 16'h8000, 8'h00, 1'b1, 8'h02, 4, -1, -1, 8'h02, 8'h00};
      vecs[5] = '{1'b1, 16'hFFFF, 8'h00, 1'b1, 8'h03, 4, -1, -1, 8'h03, 8'h00};
      vecs[6] = '{1'b0, 16'hF000, 8'h11, 1'b1, 8'h5A, 4,
                  PROT ? -1 : 3, PROT ? 3 : -1, 8'h03, PROT ? 8'h5A : 8'h11};
      vecs[7] = '{1'b0, 16'hDFFF, 8'h22, 1'b0, 8'h00, 4,  3, -1, 8'h03, 8'h22};
      vecs[8] = '{1'b1, 16'h0200, 8'h00, 1'b0, 8'h00, 2, -1, -1, 8'h77, 8'h00};

      for (int i = 0; i < 9; i++) begin
         if (vecs[i].pre_en) begin
            mem[vecs[i].addr]       = vecs[i].pre_val;
            model_mem[vecs[i].addr] = vecs[i].pre_val;
         end
         do_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].addr, vecs[i].wd,
                vecs[i].rdy, vecs[i].we, vecs[i].flt, vecs[i].rdata, vecs[i].mem_after);
      end

      // Reset in the middle of a slow write: no strobe, outputs back to reset values
      mem[16'h9100]       = 8'h44;
      model_mem[16'h9100] = 8'h44;
      sq_we  = 0;
      sq_rdy = 0;
      bus.cpu_req   = 1'b1;
      bus.cpu_addr  = 16'h9100;
      bus.cpu_rw    = 1'b0;
      bus.cpu_wdata = 8'h66;
      for (int c = 0; c < 7; c++) begin
         if (c == 2) begin
            rst         = 1'b1;
            bus.cpu_req = 1'b0;
         end
         if (c == 3) rst = 1'b0;
         @(negedge clk);
         if (mem_we) begin
            sq_we++;
            mem[mem_addr] = mem_wdata;
         end
         if (bus.ready) sq_rdy++;
         if (c == 3) begin
            chk("rstmid ready", int'(bus.ready), 0);
            chk("rstmid cpu_rdata", int'(bus.cpu_rdata), 0);
            chk("rstmid mem_addr", int'(mem_addr), 0);
            chk("rstmid mem_wdata", int'(mem_wdata), 0);
         end
         @(posedge clk);
         #1;
      end
      chk("rstmid we count", sq_we, 0);
      chk("rstmid ready count", sq_rdy, 0);
      chk("rstmid mem content", int'(mem[16'h9100]), 8'h44);
      last_rdata = 8'h00;

      // Back-to-back fast reads with cpu_req held and cpu_* scrambled during ACCESS/ACK
      mem[16'h0030] = 8'hB1;  model_mem[16'h0030] = 8'hB1;
      mem[16'h0031] = 8'hB2;  model_mem[16'h0031] = 8'hB2;
      sq_we    = 0;
      rdy_mask = '0;
      bus.cpu_req   = 1'b1;
      bus.cpu_addr  = 16'h0030;
      bus.cpu_rw    = 1'b1;
      bus.cpu_wdata = 8'h00;
      for (int c = 0; c < 10; c++) begin
         if (c == 1 || c == 2 || c == 4 || c == 5) begin
            bus.cpu_addr  = 16'hABCD;
            bus.cpu_rw    = 1'b0;
            bus.cpu_wdata = 8'hEE;
         end
         if (c == 3) begin
            bus.cpu_addr = 16'h0031;
            bus.cpu_rw   = 1'b1;
         end
         if (c == 6) bus.cpu_req = 1'b0;
         @(negedge clk);
         rdy_mask[c] = bus.ready;
         if (mem_we) begin
            sq_we++;
            mem[mem_addr] = mem_wdata;
         end
         if (c == 2) begin
            chk("b2b first mem_addr", int'(mem_addr), 16'h0030);
            chk("b2b first rdata", int'(bus.cpu_rdata), 8'hB1);
         end
         if (c == 5) begin
            chk("b2b second mem_addr", int'(mem_addr), 16'h0031);
            chk("b2b second rdata", int'(bus.cpu_rdata), 8'hB2);
         end
         @(posedge clk);
         #1;
      end
      chk("b2b ready cycles", int'(rdy_mask), 10'b00_0010_0100);
      chk("b2b we count", sq_we, 0);
      last_rdata = 8'hB2;

      // Random requests against the model
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 3))
            0:       a = 16'($urandom_range(0, 32767));
            1:       a = 16'($urandom_range(32768, 65535));
            2:       a = edge_addrs[$urandom_range(0, 5)];
            default: a = 16'h0040 + 16'($urandom_range(0, 7));
         endcase
         rd  = 1'($urandom_range(0, 1));
         wd  = 8'($urandom);
         w   = (a < 16'h8000) ? 0 : SLOW_W;
         blk = PROT && !rd && (a >= 16'hE000);
         do_txn($sformatf("rnd%0d", n), rd, a, wd,
                2 + w,
                (!rd && !blk) ? 1 + w : -1,
                blk ? 1 + w : -1,
                rd ? model_mem[a] : last_rdata,
                (!rd && !blk) ? wd : model_mem[a]);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
